// File: rtl/sandbox_cmd_engine.sv
// Buffered host command engine: captures commands into a FIFO, executes them
// against an indexed value store, and returns one status/data response each.
module sandbox_cmd_engine #(
  parameter int DATA_W     = 32,
  parameter int VALUE_W    = 8,
  parameter int ENTRIES    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int IND_CYCLES = 1000000
) (
  input  logic              masterClock,
  input  logic              reset,
  input  logic              dataReceived,
  input  logic [7:0]        control,
  input  logic [DATA_W-1:0] inputData,
  input  logic              txAck,
  output logic              clearDR,
  output logic              transmitData,
  output logic [7:0]        status,
  output logic [DATA_W-1:0] outputData,
  output logic              rxIndicator
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int IND_W = (IND_CYCLES > 1) ? $clog2(IND_CYCLES + 1) : 1;
  localparam int CMD_W = 3 + DATA_W;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;

  typedef enum logic { RX_IDLE, RX_WAIT } rx_state_e;
  typedef enum logic { EX_IDLE, EX_TX }   ex_state_e;

  rx_state_e rx_state, rx_next;
  ex_state_e ex_state, ex_next;

  logic [CMD_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic               full, empty, push, pop;

  logic [VALUE_W-1:0] store [ENTRIES];
  logic [ENTRIES-1:0] valid;
  logic [3:0]         seq;
  logic [IND_W-1:0]   ind_cnt;

  logic [CMD_W-1:0]   head;
  logic [2:0]         head_op;
  logic [DATA_W-1:0]  head_data;
  logic [7:0]         idx;
  logic [IDX_W-1:0]   idx_a;
  logic [VALUE_W-1:0] wval;
  logic               in_range, old_valid;
  logic [3:0]         rsp_flags;
  logic [DATA_W-1:0]  rsp_data;
  logic               do_write, do_clear;

  // control[7:3] carries no meaning for this engine
  logic unused_ctrl;
  assign unused_ctrl = ^control[7:3];

  assign full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      ex_state <= EX_IDLE;
    end else begin
      rx_state <= rx_next;
      ex_state <= ex_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    push    = 1'b0;
    case (rx_state)
      RX_IDLE: if (dataReceived && !full) begin
        push    = 1'b1;
        rx_next = RX_WAIT;
      end
      RX_WAIT: if (!dataReceived) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    ex_next = ex_state;
    pop     = 1'b0;
    case (ex_state)
      EX_IDLE: if (!empty) begin
        pop     = 1'b1;
        ex_next = EX_TX;
      end
      EX_TX:   if (txAck) ex_next = EX_IDLE;
      default: ex_next = EX_IDLE;
    endcase
  end

  assign clearDR      = (rx_state == RX_WAIT);
  assign transmitData = (ex_state == EX_TX);

  always_ff @(posedge masterClock) begin
    if (push) fifo_mem[wr_ptr] <= {control[2:0], inputData};
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign head_op   = head[CMD_W-1:DATA_W];
  assign head_data = head[DATA_W-1:0];
  assign idx       = head_data[7:0];
  assign idx_a     = idx[IDX_W-1:0];
  assign wval      = head_data[8+VALUE_W-1:8];
  assign in_range  = ({1'b0, idx} < 9'(ENTRIES));
  assign old_valid = valid[idx_a];

  // WRITE reports the value it displaces, so READ and WRITE share the lookup path
  always_comb begin
    rsp_flags = '0;
    rsp_data  = '0;
    do_write  = 1'b0;
    do_clear  = 1'b0;
    case (head_op)
      OP_NOP: begin
        rsp_data     = head_data;
        rsp_flags[0] = 1'b1;
      end
      OP_WRITE, OP_READ: begin
        if (in_range) begin
          rsp_flags[0] = 1'b1;
          rsp_flags[1] = old_valid;
          if (old_valid) rsp_data = DATA_W'(store[idx_a]);
          do_write = (head_op == OP_WRITE);
        end else begin
          rsp_flags[2] = 1'b1;
        end
      end
      OP_CLEAR: begin
        rsp_flags[0] = 1'b1;
        do_clear     = 1'b1;
      end
      default: rsp_flags[3] = 1'b1;
    endcase
  end

  always_ff @(posedge masterClock) begin
    if (pop && do_write) store[idx_a] <= wval;
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      valid      <= '0;
      seq        <= '0;
      status     <= '0;
      outputData <= '0;
    end else if (pop) begin
      if (do_clear)      valid        <= '0;
      else if (do_write) valid[idx_a] <= 1'b1;
      seq        <= seq + 1'b1;
      status     <= {seq, rsp_flags};
      outputData <= rsp_data;
    end
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset)              ind_cnt <= '0;
    else if (push)           ind_cnt <= IND_W'(IND_CYCLES);
    else if (ind_cnt != '0)  ind_cnt <= ind_cnt - 1'b1;
  end

  assign rxIndicator = (ind_cnt != '0);

endmodule
